mem_bus_ram: RTL



---
 rtl/mem_bus_ram.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mem_bus_ram.sv
// mem_bus_ram: word-addressed RAM slave for the CPU memory bus.
// Serves mem_valid/mem_ready requests with WAIT_STATES extra cycles of latency,
// byte-lane write strobes and read-before-write data on writes.
// Optional feature macro: MEM_BUS_RAM_ERR_EN. When defined, any nonzero address
// bit above RAM_BITS-1 is reported on mem_error and the access is suppressed.
// When undefined, upper address bits are ignored and mem_error stays 0.
//
// state | meaning
// IDLE  | waiting for mem_valid; request fields captured on acceptance
// WAIT  | counting down wait states; access happens when the counter is 0
// DONE  | mem_ready high; held until mem_valid is sampled low
module mem_bus_ram #(
    parameter int    DATA_WIDTH  = 32,
    parameter int    ADDR_WIDTH  = 32,
    parameter int    RAM_BITS    = 8,
    parameter int    WAIT_STATES = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mem_valid,
    input  logic                      mem_nwr,
    input  logic [ADDR_WIDTH-1:0]     mem_address,
    input  logic [DATA_WIDTH/8-1:0]   mem_wstrb,
    input  logic [DATA_WIDTH-1:0]     mem_data_in,
    output logic [DATA_WIDTH-1:0]     mem_data_out,
    output logic                      mem_ready,
    output logic                      mem_error
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << RAM_BITS;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [3:0]              r_cnt;
    logic [3:0]              w_cnt_nxt;

    logic                    r_nwr;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [NB-1:0]           r_wstrb;
    logic [DATA_WIDTH-1:0]   r_wdata;

    logic [DATA_WIDTH-1:0]   r_dout;
    logic                    r_ready;
    logic                    r_error;

    logic [DATA_WIDTH-1:0]   r_mem [0:DEPTH-1];

    logic                    w_use_live;
    logic                    w_acc_nwr;
    logic [ADDR_WIDTH-1:0]   w_acc_addr;
    logic [NB-1:0]           w_acc_wstrb;
    logic [DATA_WIDTH-1:0]   w_acc_wdata;
    logic [RAM_BITS-1:0]     w_idx;
    logic                    w_do_access;
    logic                    w_oor;
    logic                    w_wr_en;

    // With zero wait states the access happens on the accepting edge, so the
    // live bus fields are used; otherwise the captured copy is used.
    assign w_use_live  = (r_state == IDLE);
    assign w_acc_nwr   = w_use_live ? mem_nwr     : r_nwr;
    assign w_acc_addr  = w_use_live ? mem_address : r_addr;
    assign w_acc_wstrb = w_use_live ? mem_wstrb   : r_wstrb;
    assign w_acc_wdata = w_use_live ? mem_data_in : r_wdata;
    assign w_idx       = w_acc_addr[RAM_BITS-1:0];

    assign w_do_access = ((r_state == IDLE) && mem_valid && (WAIT_STATES == 0)) ||
                         ((r_state == WAIT) && (r_cnt == 4'd0));

`ifdef MEM_BUS_RAM_ERR_EN
    assign w_oor = |w_acc_addr[ADDR_WIDTH-1:RAM_BITS];
`else
    logic w_unused_upper;
    assign w_oor          = 1'b0;
    assign w_unused_upper = ^w_acc_addr[ADDR_WIDTH-1:RAM_BITS];
`endif

    // Reset on the access edge must discard the pending write.
    assign w_wr_en = w_do_access && !reset && !w_acc_nwr && !w_oor;

    assign mem_data_out = r_dout;
    assign mem_ready    = r_ready;
    assign mem_error    = r_error;

    // Next-state and wait-counter logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (mem_valid) begin
                    if (WAIT_STATES == 0) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = 4'(WAIT_STATES - 1);
                    end
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = DONE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            DONE: begin
                if (!mem_valid) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register, request capture and bus response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_nwr   <= 1'b1;
            r_addr  <= '0;
            r_wstrb <= '0;
            r_wdata <= '0;
            r_dout  <= '0;
            r_ready <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if ((r_state == IDLE) && mem_valid) begin
                r_nwr   <= mem_nwr;
                r_addr  <= mem_address;
                r_wstrb <= mem_wstrb;
                r_wdata <= mem_data_in;
            end
            if (w_do_access) begin
                r_ready <= 1'b1;
                r_error <= w_oor;
                if (!w_oor) begin
                    r_dout <= r_mem[w_idx];
                end
            end else if ((r_state == DONE) && !mem_valid) begin
                r_ready <= 1'b0;
                r_error <= 1'b0;
            end
        end
    end

    // Byte-lane write port; no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (w_acc_wstrb[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
